// File: rtl/uart_tx_arb.sv
// -----------------------------------------------------------------------------
// uart_tx_arb
//
// Round-robin arbiter that shares one UART transmitter between three byte-level
// requesters (0: command FSM status, 1: barcode/station report, 2: obstacle/
// buzzer alert). It owns the transmitter's start strobe and data byte. It sends
// one byte per grant. Each byte completes on a rising edge of tx_done_i. A
// watchdog returns the arbiter to IDLE if that edge never arrives.
//
// Parameters:
//   TO_CYC    clock cycles allowed after LOAD before err_o pulses (>= 2)
//   TO_W      watchdog counter width, 2**TO_W > TO_CYC
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   req_i      level request per requester, held until its ack
//   data0_i    byte offered by requester 0 (stable while req_i[0] is high)
//   data1_i    byte offered by requester 1 (stable while req_i[1] is high)
//   data2_i    byte offered by requester 2 (stable while req_i[2] is high)
//   ack_o      one-hot 1-cycle pulse: granted byte latched, requester released
//   done_o     one-hot 1-cycle pulse: granted byte finished transmitting
//   gnt_o      one-hot grant, held from LOAD through the end of WAIT
//   trmt_o     1-cycle start strobe to the transmitter
//   tx_data_o  byte to the transmitter, held stable for the whole grant
//   tx_done_i  transmitter completion level (only its rising edge is used)
//   busy_o     high whenever the arbiter is not IDLE
//   err_o      1-cycle pulse when the watchdog expires
// -----------------------------------------------------------------------------
module uart_tx_arb #(
  parameter int TO_CYC = 60000,
  parameter int TO_W   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req_i,
  input  logic [7:0] data0_i,
  input  logic [7:0] data1_i,
  input  logic [7:0] data2_i,
  output logic [2:0] ack_o,
  output logic [2:0] done_o,
  output logic [2:0] gnt_o,
  output logic       trmt_o,
  output logic [7:0] tx_data_o,
  input  logic       tx_done_i,
  output logic       busy_o,
  output logic       err_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  // The watchdog counter holds the number of cycles elapsed since LOAD.
  // It reads 0 during LOAD, so reaching TO_CYC-1 in WAIT puts err_o exactly
  // TO_CYC cycles after LOAD.
  localparam logic [TO_W-1:0] WD_LAST = TO_W'(TO_CYC - 1);
  localparam logic [TO_W-1:0] WD_ONE  = TO_W'(1);

  state_e          state_q;
  logic [1:0]      last_q;
  logic [1:0]      gidx_q;
  logic [2:0]      gnt_q;
  logic [2:0]      ack_q;
  logic [2:0]      done_q;
  logic            trmt_q;
  logic            err_q;
  logic            tx_done_q;
  logic [7:0]      tx_data_q;
  logic [TO_W-1:0] wd_cnt_q;

  // ---------------------------------------------------------------------------
  // Round-robin selection. cand[k] is the requester with priority rank k,
  // starting at last_q+1 (mod 3) and ending at last_q itself.
  // ---------------------------------------------------------------------------
  logic [1:0] cand [3];

  for (genvar gi = 0; gi < 3; gi++) begin : g_cand
    logic [2:0] sum;
    assign sum       = {1'b0, last_q} + 3'(gi + 1);
    assign cand[gi]  = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
  end

  logic       pick_vld;
  logic [1:0] pick_idx;
  logic [2:0] pick_oh;
  logic [7:0] pick_data;

  always_comb begin
    pick_vld = 1'b0;
    pick_idx = 2'd0;
    // Walk from lowest to highest priority so the highest-ranked hit wins.
    for (int k = 2; k >= 0; k--) begin
      if (req_i[cand[k]]) begin
        pick_vld = 1'b1;
        pick_idx = cand[k];
      end
    end
  end

  assign pick_oh = 3'b001 << pick_idx;

  always_comb begin
    case (pick_idx)
      2'd0:    pick_data = data0_i;
      2'd1:    pick_data = data1_i;
      default: pick_data = data2_i;
    endcase
  end

  logic tx_done_rise;
  assign tx_done_rise = tx_done_i & ~tx_done_q;

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      last_q    <= 2'd2;
      gidx_q    <= 2'd0;
      gnt_q     <= 3'b000;
      ack_q     <= 3'b000;
      done_q    <= 3'b000;
      trmt_q    <= 1'b0;
      err_q     <= 1'b0;
      tx_done_q <= 1'b0;
      tx_data_q <= 8'h00;
      wd_cnt_q  <= '0;
    end else begin
      tx_done_q <= tx_done_i;
      // Strobe outputs are single-cycle pulses by default.
      trmt_q    <= 1'b0;
      ack_q     <= 3'b000;
      done_q    <= 3'b000;
      err_q     <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (pick_vld) begin
            gnt_q     <= pick_oh;
            gidx_q    <= pick_idx;
            tx_data_q <= pick_data;
            trmt_q    <= 1'b1;
            ack_q     <= pick_oh;
            wd_cnt_q  <= '0;
            state_q   <= S_LOAD;
          end
        end

        S_LOAD: begin
          last_q   <= gidx_q;
          wd_cnt_q <= WD_ONE;
          state_q  <= S_WAIT;
        end

        S_WAIT: begin
          // A completion edge takes precedence over a coincident timeout.
          if (tx_done_rise) begin
            done_q  <= gnt_q;
            gnt_q   <= 3'b000;
            state_q <= S_IDLE;
          end else if (wd_cnt_q == WD_LAST) begin
            err_q   <= 1'b1;
            gnt_q   <= 3'b000;
            state_q <= S_IDLE;
          end else begin
            wd_cnt_q <= wd_cnt_q + WD_ONE;
          end
        end

        default: begin
          gnt_q   <= 3'b000;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ack_o     = ack_q;
  assign done_o    = done_q;
  assign gnt_o     = gnt_q;
  assign trmt_o    = trmt_q;
  assign tx_data_o = tx_data_q;
  assign err_o     = err_q;
  assign busy_o    = (state_q != S_IDLE);

endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Round-robin arbiter that shares the single `UART_tx` transmitter between three byte-level requesters: command FSM status, barcode/station-arrival report, and obstacle/buzzer alert. It sits between those requesters and `UART_tx`. It owns `trmt` and `tx_data` and sequences one byte at a time, completing each on the transmitter's `tx_done` edge. A watchdog recovers the arbiter if `tx_done` never arrives.

## Interface
Parameters:
- `TO_CYC`, default 60000. Clock cycles allowed in WAIT before declaring a timeout. Must be ≥ 2.
- `TO_W`, default 16. Width of the watchdog counter. Must satisfy 2^TO_W > TO_CYC.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req` in 3: level request per requester. Held until `ack`.
- `data0` / `data1` / `data2` in 8: byte offered by requester 0/1/2. Must be stable while its `req` is high.
- `ack` out 3: one-hot, 1-cycle pulse. The granted byte has been latched, and the requester may change its data or drop `req`.
- `done` out 3: one-hot, 1-cycle pulse. The granted byte has finished transmitting.
- `gnt` out 3: one-hot grant, held from LOAD through the end of WAIT.
- `trmt` out 1: 1-cycle start strobe to `UART_tx`.
- `tx_data` out 8: byte to `UART_tx`. Registered and held stable for the whole grant.
- `tx_done` in 1: from `UART_tx`. Only its rising edge is used.
- `busy` out 1: high when the state is not IDLE.
- `err` out 1: 1-cycle pulse on watchdog timeout.

## Operation
- **States:** IDLE, LOAD, WAIT.
- **IDLE:**
  - If `req` is nonzero, pick the winner by round-robin starting after `last`.
  - Register the winner in `gnt`, copy its `dataN` into `tx_data`, go to LOAD.
  - If `req` is zero, stay in IDLE.
- **LOAD (exactly 1 cycle):**
  - Assert `trmt=1` and `ack[g]=1`.
  - Clear the watchdog counter.
  - Set `last` to g, then go to WAIT.
- **WAIT:**
  - Each cycle the counter increments.
  - On a `tx_done` rising edge (`tx_done & ~tx_done_q`, with `tx_done_q` a 1-flop delay), pulse `done[g]`, clear `gnt`, go to IDLE.
  - Otherwise, when the counter reaches `TO_CYC`-1, pulse `err`, clear `gnt`, go to IDLE. No `done` is issued.
- **Round-robin:**
  - Priority order is `last`+1, `last`+2, `last` (mod 3).
  - `last` resets to 2, so requester 0 wins first after reset.
  - A requester holding `req` continuously is served at least once every 3 grants.
- **Requests:**
  - `req` changes during LOAD/WAIT are ignored. Only IDLE samples `req`.
  - A `req` dropped before grant is never granted.
  - A requester still holding `req` after `ack` is treated as offering its next byte.

## Timing
- **Reset values:** state=IDLE, `last`=2, `gnt`=0, `ack`=0, `done`=0, `trmt`=0, `tx_data`=8'h00, `err`=0, `busy`=0, `tx_done_q`=0, counter=0.
- **Grant latency:** `req` sampled high at edge n in IDLE → at edge n+1 the state is LOAD, with `trmt`, `ack`, `gnt`, `tx_data` valid during cycle n+1. At edge n+2 the state is WAIT.
- **Completion:** `tx_done` sampled rising at edge m in WAIT → `done` is high during cycle m+1, state is IDLE at m+1.
  - The earliest next grant is LOAD at m+2, giving a 1 idle cycle gap between back-to-back bytes.
- **`tx_done` before entering WAIT:** a `tx_done` level already high on entry to WAIT (stale from the previous byte) causes no completion. An edge is required.
- **Simultaneous edge and timeout:** completion wins; `done` pulses and `err` does not.
- **Timeout cycle count:** `err` appears TO_CYC cycles after LOAD.
- **Reset mid-operation:** all outputs return to reset values asynchronously.
  - No `done` or `err` is emitted for the aborted byte.
  - `last` returns to 2.
- **Exclusivity:** `ack`, `done` and `gnt` are one-hot or zero at all times; never more than one bit set.

## Test plan
- **Single request:** `req`=3'b010, `data1`=8'hA5 → `trmt` pulse 2 cycles after `req`, `tx_data`=A5, `ack`=010. The receiving `UART_rx` yields `cmd`=A5, then `done`=010 one cycle after the `tx_done` rise, and `busy` falls.
- **All three requesting from reset:** `req`=3'b111 held, data 8'h11/22/33 → bytes sent 11, 22, 33, 11, in that order. Each `ack` is exactly one pulse per byte.
- **Fairness:** `req0` held constantly while `req2` asserts after the first grant → grant order 0, 2, 0, 2. `req2` waits at most one transfer.
- **Timeout:** `TO_CYC`=50, `tx_done` tied 0, `req`=001 → `err` pulses exactly 50 cycles after LOAD, no `done`. The next byte is granted afterwards, with `last`=0, so requester 1 has priority.
- **Reset mid-WAIT:** assert `rst_n`=0 20 cycles into a transfer → all outputs 0 immediately. After release with `req`=3'b101, requester 0 is granted first.
- **Stale `tx_done` high:** hold `tx_done`=1 entering WAIT, drop it, raise it again 30 cycles later → `done` occurs only after the second rise.
